// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_mem_arbiter
//  Description : Shares one BIU-style memory port between NREQ requesters.
//                One request is accepted per cycle, with zero latency.
//                Each accepted transfer is remembered in an in-order ID FIFO
//                (up to MAX_OUTST deep) so that upstream ack/err and read
//                data are routed back to the requester that issued it.
//                Build option ARB_ROUND_ROBIN_EN selects round-robin
//                arbitration. Without it, arbitration is fixed priority and
//                the highest index wins. A lock held by the current owner
//                overrides either policy.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_mem_arbiter #(
    parameter int XLEN      = 32,
    parameter int NREQ      = 2,
    parameter int MAX_OUTST = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,

    // requester side
    input  logic [NREQ-1:0]        s_req_i,
    input  logic [NREQ*XLEN-1:0]   s_adr_i,
    input  logic [NREQ*3-1:0]      s_size_i,
    input  logic [NREQ*3-1:0]      s_type_i,
    input  logic [NREQ*3-1:0]      s_prot_i,
    input  logic [NREQ-1:0]        s_lock_i,
    input  logic [NREQ-1:0]        s_we_i,
    input  logic [NREQ*XLEN-1:0]   s_d_i,
    output logic [NREQ-1:0]        s_gnt_o,
    output logic [XLEN-1:0]        s_q_o,
    output logic [NREQ-1:0]        s_ack_o,
    output logic [NREQ-1:0]        s_err_o,

    // shared upstream port
    output logic                   mem_req_o,
    output logic [XLEN-1:0]        mem_adr_o,
    output logic [2:0]             mem_size_o,
    output logic [2:0]             mem_type_o,
    output logic                   mem_lock_o,
    output logic [2:0]             mem_prot_o,
    output logic                   mem_we_o,
    output logic [XLEN-1:0]        mem_d_o,
    input  logic [XLEN-1:0]        mem_q_i,
    input  logic                   mem_ack_i,
    input  logic                   mem_err_i
);

    // BIU size/type/prot field widths
    localparam int SIZE_W = 3;
    localparam int TYPE_W = 3;
    localparam int PROT_W = 3;

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;       // requester id width
    localparam int PW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1; // FIFO pointer width
    localparam int CW  = PW + 1;                              // occupancy count width

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDW-1:0] ids_q [MAX_OUTST];   // requester id per outstanding transfer
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           lock_vld_q, lock_vld_d;
    logic [IDW-1:0] lock_own_q, lock_own_d;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic           w_empty;
    logic           w_can_issue;
    logic           w_pop;
    logic           w_push;
    logic           w_any;
    logic [IDW-1:0] w_win;
    logic [IDW-1:0] w_head;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

    // (base + off) modulo NREQ, for off in 0..NREQ
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        int t;
        t = int'(base) + off;
        if (t >= NREQ) begin
            t = t - NREQ;
        end
        return IDW'(t);
    endfunction
`endif

    assign w_empty     = (cnt_q == '0);
    // An ack/err in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_can_issue = (cnt_q < CW'(MAX_OUTST)) | mem_ack_i | mem_err_i;
    // Responses with nothing outstanding are spurious and dropped.
    assign w_pop       = (mem_ack_i | mem_err_i) & ~w_empty;
    assign w_head      = ids_q[rd_ptr_q];

    // Winner selection: the lock owner if there is one, otherwise the policy.
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        if (lock_vld_q) begin
            // Only the owner may be granted; an idle owner blocks everyone.
            w_win = lock_own_q;
            w_any = s_req_i[lock_own_q];
        end else begin
`ifdef ARB_ROUND_ROBIN_EN
            // Walk offsets from far to near so the nearest requester from
            // rr_ptr ends up as the winner.
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (s_req_i[wrap_add(rr_ptr_q, i)]) begin
                    w_win = wrap_add(rr_ptr_q, i);
                    w_any = 1'b1;
                end
            end
`else
            // Fixed priority: the last (highest) index seen wins.
            for (int i = 0; i < NREQ; i++) begin
                if (s_req_i[i]) begin
                    w_win = IDW'(i);
                    w_any = 1'b1;
                end
            end
`endif
        end
    end

    assign mem_req_o = rst_ni & w_any & w_can_issue;
    assign w_push    = mem_req_o;
    assign s_q_o     = mem_q_i;

    // Forward the winner's transfer attributes upstream.
    always_comb begin
        mem_adr_o  = '0;
        mem_size_o = '0;
        mem_type_o = '0;
        mem_prot_o = '0;
        mem_lock_o = 1'b0;
        mem_we_o   = 1'b0;
        mem_d_o    = '0;
        for (int s = 0; s < NREQ; s++) begin
            if (w_win == IDW'(s)) begin
                mem_adr_o  = s_adr_i[s*XLEN +: XLEN];
                mem_size_o = s_size_i[s*SIZE_W +: SIZE_W];
                mem_type_o = s_type_i[s*TYPE_W +: TYPE_W];
                mem_prot_o = s_prot_i[s*PROT_W +: PROT_W];
                mem_lock_o = s_lock_i[s];
                mem_we_o   = s_we_i[s];
                mem_d_o    = s_d_i[s*XLEN +: XLEN];
            end
        end
    end

    // Per-requester grant and response decode (grant to winner, ack/err to FIFO head).
    always_comb begin
        s_gnt_o = '0;
        s_ack_o = '0;
        s_err_o = '0;
        for (int s = 0; s < NREQ; s++) begin
            s_gnt_o[s] = mem_req_o & (w_win == IDW'(s));
            s_ack_o[s] = rst_ni & mem_ack_i & ~w_empty & (w_head == IDW'(s));
            s_err_o[s] = rst_ni & mem_err_i & ~w_empty & (w_head == IDW'(s));
        end
    end

    // Next-state for FIFO pointers and outstanding count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        cnt_d = cnt_q + CW'(w_push) - CW'(w_pop);
    end

    // Next-state for the lock: drop when the owner releases lock or request,
    // (re)take when an accepted transfer carries lock.
    always_comb begin
        lock_vld_d = lock_vld_q;
        lock_own_d = lock_own_q;
        if (lock_vld_q && (!s_req_i[lock_own_q] || !s_lock_i[lock_own_q])) begin
            lock_vld_d = 1'b0;
        end
        if (w_push && s_lock_i[w_win]) begin
            lock_vld_d = 1'b1;
            lock_own_d = w_win;
        end
    end

    // FIFO pointers, count and lock registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            lock_vld_q <= 1'b0;
            lock_own_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
        end
    end

    // ID storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (rst_ni && w_push) begin
            ids_q[wr_ptr_q] <= w_win;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Round-robin pointer moves past the winner on each accept outside a lock.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_push && !lock_vld_q) begin
            rr_ptr_d = wrap_add(w_win, 1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_mem_arbiter
//  Description : Scoreboard bench for riscv_mem_arbiter. A queue-based model
//                predicts grants and responses; a negedge monitor compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_mem_arbiter;

    localparam int XLEN      = 32;
    localparam int NREQ      = 2;
    localparam int MAX_OUTST = 4;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [NREQ-1:0]      s_req_i;
    logic [NREQ*XLEN-1:0] s_adr_i;
    logic [NREQ*3-1:0]    s_size_i, s_type_i, s_prot_i;
    logic [NREQ-1:0]      s_lock_i, s_we_i;
    logic [NREQ*XLEN-1:0] s_d_i;
    logic [NREQ-1:0]      s_gnt_o, s_ack_o, s_err_o;
    logic [XLEN-1:0]      s_q_o;
    logic                 mem_req_o, mem_lock_o, mem_we_o;
    logic [XLEN-1:0]      mem_adr_o, mem_d_o, mem_q_i;
    logic [2:0]           mem_size_o, mem_type_o, mem_prot_o;
    logic                 mem_ack_i, mem_err_i;

    riscv_mem_arbiter #(.XLEN(XLEN), .NREQ(NREQ), .MAX_OUTST(MAX_OUTST)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_req_i(s_req_i), .s_adr_i(s_adr_i), .s_size_i(s_size_i),
        .s_type_i(s_type_i), .s_prot_i(s_prot_i), .s_lock_i(s_lock_i),
        .s_we_i(s_we_i), .s_d_i(s_d_i), .s_gnt_o(s_gnt_o), .s_q_o(s_q_o),
        .s_ack_o(s_ack_o), .s_err_o(s_err_o),
        .mem_req_o(mem_req_o), .mem_adr_o(mem_adr_o), .mem_size_o(mem_size_o),
        .mem_type_o(mem_type_o), .mem_lock_o(mem_lock_o), .mem_prot_o(mem_prot_o),
        .mem_we_o(mem_we_o), .mem_d_o(mem_d_o), .mem_q_i(mem_q_i),
        .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic            req;
        logic [NREQ-1:0] gnt;
        logic [XLEN-1:0] adr;
        logic            we;
    } gexp_t;

    typedef struct {
        logic [NREQ-1:0] ack;
        logic [NREQ-1:0] err;
        logic [XLEN-1:0] q;
        int              cyc;
    } rexp_t;

    gexp_t gnt_q[$];
    rexp_t rsp_q[$];
    int    checks = 0;
    int    fails  = 0;
    int    cyc    = 0;
    bit    mon_en = 1'b0;

    // reference model state
    int              outst[$];     // requester ids in issue order
    int              lock_own = -1;
    int              rr = 0;
    logic [XLEN-1:0] adr_cur [NREQ];

    // One cycle: drive inputs, predict, let the edge pass, advance the model.
    task automatic step(input bit rst, input logic [NREQ-1:0] req, input logic [NREQ-1:0] lck,
                        input bit ack, input bit err, input logic [XLEN-1:0] q, output int gw);
        int    w;
        int    j;
        bit    anyr, can, acc, popv, was_locked;
        gexp_t g;
        rexp_t r;
        rst_ni   = rst;
        s_req_i  = req;
        s_lock_i = lck;
        for (int s = 0; s < NREQ; s++) begin
            s_adr_i[s*XLEN +: XLEN] = adr_cur[s];
            s_d_i[s*XLEN +: XLEN]   = $urandom;
            s_size_i[s*3 +: 3]      = 3'($urandom);
            s_type_i[s*3 +: 3]      = 3'($urandom);
            s_prot_i[s*3 +: 3]      = 3'($urandom);
        end
        s_we_i    = NREQ'($urandom);
        mem_ack_i = ack;
        mem_err_i = err;
        mem_q_i   = q;
        cyc++;

        w    = -1;
        anyr = 1'b0;
        if (lock_own >= 0) begin
            w    = lock_own;
            anyr = req[lock_own];
        end else if (RR_MODE) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (rr + k) % NREQ;
                if (req[j] && w < 0) w = j;
            end
            anyr = (w >= 0);
        end else begin
            for (int k = 0; k < NREQ; k++) if (req[k]) w = k;
            anyr = (w >= 0);
        end
        can  = (outst.size() < MAX_OUTST) || ack || err;
        acc  = rst && anyr && can;
        popv = (ack || err) && (outst.size() > 0);

        g.req = acc;
        g.gnt = '0;
        g.adr = '0;
        g.we  = 1'b0;
        if (acc) begin
            g.gnt[w] = 1'b1;
            g.adr    = adr_cur[w];
            g.we     = s_we_i[w];
        end
        gnt_q.push_back(g);
        if (rst && popv) begin
            r.ack = '0;
            r.err = '0;
            if (ack) r.ack[outst[0]] = 1'b1;
            if (err) r.err[outst[0]] = 1'b1;
            r.q   = q;
            r.cyc = cyc;
            rsp_q.push_back(r);
        end
        mon_en = 1'b1;

        @(posedge clk_i);
        #1;
        if (!rst) begin
            outst.delete();
            lock_own = -1;
            rr       = 0;
        end else begin
            if (popv) void'(outst.pop_front());
            if (acc) outst.push_back(w);
            was_locked = (lock_own >= 0);
            if (lock_own >= 0 && (!req[lock_own] || !lck[lock_own])) lock_own = -1;
            if (acc && lck[w]) lock_own = w;
            if (acc && !was_locked) rr = (w + 1) % NREQ;
        end
        gw = acc ? w : -1;
    endtask

    // Monitor: grants every cycle, responses whenever the DUT shows one.
    always @(negedge clk_i) begin
        gexp_t g;
        rexp_t r;
        if (mon_en && gnt_q.size() > 0) begin
            g = gnt_q.pop_front();
            checks++;
            if (mem_req_o !== g.req || s_gnt_o !== g.gnt) begin
                fails++;
                $display("FAIL grant cyc=%0d got req=%b gnt=%b want req=%b gnt=%b",
                         cyc, mem_req_o, s_gnt_o, g.req, g.gnt);
            end
            if (g.req) begin
                checks++;
                if (mem_adr_o !== g.adr || mem_we_o !== g.we) begin
                    fails++;
                    $display("FAIL fields cyc=%0d got adr=%h we=%b want adr=%h we=%b",
                             cyc, mem_adr_o, mem_we_o, g.adr, g.we);
                end
            end
            if ((s_ack_o | s_err_o) !== '0) begin
                checks++;
                if (rsp_q.size() == 0) begin
                    fails++;
                    $display("FAIL spurious_rsp cyc=%0d got ack=%b err=%b want none",
                             cyc, s_ack_o, s_err_o);
                end else begin
                    r = rsp_q.pop_front();
                    if (s_ack_o !== r.ack || s_err_o !== r.err || s_q_o !== r.q || r.cyc != cyc) begin
                        fails++;
                        $display("FAIL response cyc=%0d got ack=%b err=%b q=%h want ack=%b err=%b q=%h at cyc=%0d",
                                 cyc, s_ack_o, s_err_o, s_q_o, r.ack, r.err, r.q, r.cyc);
                    end
                end
            end else if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
                checks++;
                fails++;
                r = rsp_q.pop_front();
                $display("FAIL missing_rsp cyc=%0d got ack=%b err=%b want ack=%b err=%b",
                         cyc, s_ack_o, s_err_o, r.ack, r.err);
            end
        end
    end

    initial begin
        int              gw;
        logic [NREQ-1:0] pend, lck;
        for (int s = 0; s < NREQ; s++) adr_cur[s] = $urandom;
        rst_ni = 1'b0; s_req_i = '0; s_lock_i = '0; s_we_i = '0;
        s_adr_i = '0; s_d_i = '0; s_size_i = '0; s_type_i = '0; s_prot_i = '0;
        mem_ack_i = 1'b0; mem_err_i = 1'b0; mem_q_i = '0;
        @(posedge clk_i);
        #1;

        // reset with both requesting, then first grant after release
        repeat (3) step(0, 2'b11, 2'b00, 0, 0, $urandom, gw);
        step(1, 2'b11, 2'b00, 0, 0, $urandom, gw);
        step(0, 2'b00, 2'b00, 0, 0, $urandom, gw);

        // fill to MAX_OUTST, stall, then accept in the ack cycle; drain in order
        repeat (5) step(1, 2'b01, 2'b00, 0, 0, $urandom, gw);
        step(1, 2'b01, 2'b00, 1, 0, 32'hA0A0_0001, gw);
        repeat (4) step(1, 2'b00, 2'b00, 1, 0, $urandom, gw);

        // interleaved s0,s1,s0 with distinct read data
        step(1, 2'b01, 2'b00, 0, 0, $urandom, gw);
        step(1, 2'b10, 2'b00, 0, 0, $urandom, gw);
        step(1, 2'b01, 2'b00, 0, 0, $urandom, gw);
        step(1, 2'b00, 2'b00, 1, 0, 32'hAAAA_AAAA, gw);
        step(1, 2'b00, 2'b00, 1, 0, 32'hBBBB_BBBB, gw);
        step(1, 2'b00, 2'b00, 1, 0, 32'hCCCC_CCCC, gw);

        // s1 holds lock for 3 transfers while s0 waits
        step(1, 2'b10, 2'b10, 0, 0, $urandom, gw);
        step(1, 2'b11, 2'b10, 0, 0, $urandom, gw);
        step(1, 2'b11, 2'b10, 1, 0, $urandom, gw);
        step(1, 2'b01, 2'b00, 0, 0, $urandom, gw);
        step(1, 2'b01, 2'b00, 0, 0, $urandom, gw);
        repeat (4) step(1, 2'b00, 2'b00, 1, 0, $urandom, gw);

        // error on second outstanding transfer, owned by s1
        step(0, 2'b00, 2'b00, 0, 0, $urandom, gw);
        step(1, 2'b01, 2'b00, 0, 0, $urandom, gw);
        step(1, 2'b10, 2'b00, 0, 0, $urandom, gw);
        step(1, 2'b00, 2'b00, 1, 0, $urandom, gw);
        step(1, 2'b00, 2'b00, 0, 1, $urandom, gw);
        step(1, 2'b00, 2'b00, 0, 0, $urandom, gw);

        // reset with 3 outstanding, spurious ack, then immediate accept
        repeat (3) step(1, 2'b01, 2'b00, 0, 0, $urandom, gw);
        step(0, 2'b00, 2'b00, 0, 0, $urandom, gw);
        step(1, 2'b00, 2'b00, 1, 0, $urandom, gw);
        step(1, 2'b01, 2'b00, 0, 0, $urandom, gw);
        step(1, 2'b00, 2'b00, 1, 0, $urandom, gw);

        // randomized traffic; a requester holds its request until granted
        pend = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int s = 0; s < NREQ; s++) begin
                if (!pend[s] && $urandom_range(0, 99) < 60) begin
                    pend[s]    = 1'b1;
                    adr_cur[s] = $urandom;
                end
                lck[s] = pend[s] && ($urandom_range(0, 5) == 0);
            end
            step(($urandom_range(0, 299) != 0), pend, lck,
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0), $urandom, gw);
            if (gw >= 0) pend[gw] = 1'b0;
        end
        repeat (MAX_OUTST + 2) step(1, 2'b00, 2'b00, 1, 0, $urandom, gw);

        checks++;
        if (rsp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending responses want 0", rsp_q.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
`default_nettype wire
